// File: rtl/sample_capture_buffer_if.sv
// sample_capture_buffer_if: sample stream in and address-based readback out.
interface sample_capture_buffer_if #(
    parameter int DATA_W = 64,
    parameter int AW     = 7
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    modport master (output in_data, in_valid, in_last, rd_en, rd_addr, input rd_data, rd_valid);
    modport slave  (input in_data, in_valid, in_last, rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/sample_capture_buffer.sv
// sample_capture_buffer: captures up to N samples with a running sum, then serves reads by address.
module sample_capture_buffer #(
    parameter int N      = 100,
    parameter int DATA_W = 64,
    parameter int CW     = $clog2(N + 1),
    parameter int AW     = $clog2(N),
    parameter int SW     = DATA_W + CW
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     clear,
    sample_capture_buffer_if.slave   bus,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [CW-1:0]            count,
    output logic [SW-1:0]            sum
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0]        state;
    logic [DATA_W-1:0] mem [N];
    assign busy = state == LOAD;
    assign done = state == DONE;
    always_ff @(posedge clock)
        if (state == LOAD && bus.in_valid) mem[count[AW-1:0]] <= bus.in_data;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count        <= '0;
            sum          <= '0;
            overflow     <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= LOAD;
                    count    <= '0;
                    sum      <= '0;
                    overflow <= 1'b0;
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        count <= count + 1'b1;
                        sum   <= sum + SW'(bus.in_data);
                    end
                    // leaving on the Nth write keeps count from ever passing N
                    if (bus.in_last || (bus.in_valid && count == CW'(N - 1))) state <= DONE;
                end
                DONE: begin
                    if (bus.in_valid) overflow <= 1'b1;
                    if (clear) state <= IDLE;
                    if (bus.rd_en) begin
                        bus.rd_valid <= 1'b1;
                        bus.rd_data  <= CW'(bus.rd_addr) < count ? mem[bus.rd_addr] : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sample_capture_buffer.sv
// tb_sample_capture_buffer: directed checks of capture, overflow, readback and reset on N=100 and N=4 instances.
module tb_sample_capture_buffer;
    logic         clock = 1'b0;
    logic         reset_n, start, clear;
    logic         busy, done, overflow, busy4, done4, overflow4;
    logic [6:0]   count;
    logic [70:0]  sum;
    logic [2:0]   count4;
    logic [66:0]  sum4;
    int           total = 0;
    int           bad = 0;
    logic [63:0]  all_ones = '1;
    sample_capture_buffer_if #(.DATA_W(64), .AW(7)) bus ();
    sample_capture_buffer_if #(.DATA_W(64), .AW(2)) b4 ();
    sample_capture_buffer #(.N(100), .DATA_W(64)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .clear(clear), .bus(bus),
        .busy(busy), .done(done), .overflow(overflow), .count(count), .sum(sum));
    sample_capture_buffer #(.N(4), .DATA_W(64)) dut4 (
        .clock(clock), .reset_n(reset_n), .start(start), .clear(clear), .bus(b4),
        .busy(busy4), .done(done4), .overflow(overflow4), .count(count4), .sum(sum4));
    always #5 clock = ~clock;
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic feed(input logic [63:0] d, input logic last);
        bus.in_data = d; bus.in_valid = 1'b1; bus.in_last = last;
        tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
    endtask
    task automatic rd(input logic [6:0] a);
        bus.rd_en = 1'b1; bus.rd_addr = a;
        tick();
        bus.rd_en = 1'b0;
    endtask
    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask
    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask
    initial begin
        reset_n = 1'b0; start = 1'b0; clear = 1'b0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
        b4.in_data = '0; b4.in_valid = 1'b0; b4.in_last = 1'b0; b4.rd_en = 1'b0; b4.rd_addr = '0;
        #2;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ovf", overflow, 0);
        chk("rst_count", count, 0); chk("rst_sum", sum, 0);
        chk("rst_rd_data", bus.rd_data, 0); chk("rst_rd_valid", bus.rd_valid, 0);
        #10 reset_n = 1'b1;
        tick();
        feed(64'd5, 1'b0);
        chk("idle_valid_count", count, 0); chk("idle_valid_busy", busy, 0);
        pulse_clear();
        chk("idle_clear_busy", busy, 0); chk("idle_clear_done", done, 0);
        pulse_start();
        chk("start_busy", busy, 1); chk("start_count", count, 0);
        pulse_clear();
        chk("load_clear_busy", busy, 1);
        rd(7'd0);
        chk("load_rd_valid", bus.rd_valid, 0);
        for (int i = 1; i <= 5; i++) begin
            feed(64'(10 * i), i == 5);
            chk("basic_count", count, i);
            chk("basic_sum", sum, 5 * i * (i + 1));
        end
        chk("basic_done", done, 1); chk("basic_busy", busy, 0); chk("basic_ovf", overflow, 0);
        pulse_start();
        chk("done_start_done", done, 1); chk("done_start_count", count, 5);
        for (int a = 0; a < 5; a++) begin
            rd(7'(a));
            chk("basic_rd_valid", bus.rd_valid, 1);
            chk("basic_rd_data", bus.rd_data, 10 * (a + 1));
        end
        rd(7'd7);
        chk("oob_rd_valid", bus.rd_valid, 1); chk("oob_rd_data", bus.rd_data, 0);
        tick();
        chk("rd_valid_pulse", bus.rd_valid, 0);
        pulse_clear();
        chk("clear_done", done, 0); chk("clear_busy", busy, 0); chk("clear_hold_count", count, 5);
        rd(7'd0);
        chk("idle_rd_valid", bus.rd_valid, 0); chk("idle_rd_hold", bus.rd_data, 0);
        pulse_start();
        for (int i = 1; i <= 102; i++) begin
            feed(64'(i), 1'b0);
            if (i == 99) chk("full_99_busy", busy, 1);
            if (i == 100) begin
                chk("full_done", done, 1); chk("full_count", count, 100);
                chk("full_sum", sum, 5050); chk("full_ovf0", overflow, 0);
            end
            if (i == 101) begin
                chk("full_ovf1", overflow, 1); chk("full_count_hold", count, 100);
            end
        end
        chk("full_sum_hold", sum, 5050);
        rd(7'd99);
        chk("full_mem99", bus.rd_data, 100);
        rd(7'd0);
        chk("full_mem0", bus.rd_data, 1);
        pulse_clear();
        pulse_start();
        chk("restart_ovf_clr", overflow, 0);
        bus.in_last = 1'b1; tick(); bus.in_last = 1'b0;
        chk("last_done", done, 1); chk("last_count", count, 0); chk("last_sum", sum, 0);
        rd(7'd0);
        chk("last_rd_valid", bus.rd_valid, 1); chk("last_rd_data", bus.rd_data, 0);
        pulse_clear();
        pulse_start();
        feed(64'd1, 1'b0); feed(64'd2, 1'b0); feed(64'd3, 1'b0);
        chk("mid_count", count, 3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_busy", busy, 0); chk("async_count", count, 0); chk("async_sum", sum, 0);
        #3 reset_n = 1'b1;
        tick();
        pulse_start();
        feed(64'd7, 1'b0); feed(64'd9, 1'b0);
        chk("post_rst_count", count, 2); chk("post_rst_sum", sum, 16); chk("post_rst_busy", busy, 1);
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        tick();
        pulse_start();
        for (int i = 1; i <= 4; i++) begin
            b4.in_data = all_ones; b4.in_valid = 1'b1;
            tick();
            chk("n4_count", count4, i);
        end
        b4.in_valid = 1'b0;
        chk("n4_done", done4, 1);
        chk("n4_sum", sum4, 128'h3_FFFF_FFFF_FFFF_FFFC);
        chk("n4_ovf", overflow4, 0);
        b4.rd_en = 1'b1; b4.rd_addr = 2'd3;
        tick();
        b4.rd_en = 1'b0;
        chk("n4_rd_data", b4.rd_data, all_ones);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sample_capture_buffer.md
# sample_capture_buffer

Downstream consumer of the file-reader stage. Accepts the reader's 64-bit sample stream and its end-of-file flag, stores up to N samples in an on-chip buffer, and accumulates their sum. Once capture ends, downstream logic or the testbench reads the samples back by address.

## Interface
- N, 100: buffer depth in samples; N ≥ 2.
- DATA_W, 64: sample width in bits.
- CW = $clog2(N+1), derived: width of the count.
- AW = $clog2(N), derived: width of the address.
- SW = DATA_W + CW, derived: width of the sum.

- clock  in  1  sole clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a capture; honoured only in IDLE.
- clear  in  1  one-cycle pulse that returns DONE to IDLE; honoured only in DONE.
- in_data  in  DATA_W  sample from the reader; unsigned.
- in_valid  in  1  in_data is valid this cycle.
- in_last  in  1  source exhausted (the reader's read-complete flag); level or pulse.
- busy  out  1  high in LOAD.
- done  out  1  high in DONE.
- overflow  out  1  sticky; a valid sample was dropped.
- count  out  CW  number of samples stored.
- sum  out  SW  unsigned sum of the stored samples.
- rd_en  in  1  read request; honoured only in DONE.
- rd_addr  in  AW  read address.
- rd_data  out  DATA_W  read data.
- rd_valid  out  1  rd_data is valid this cycle.

## Operation
- FSM states are IDLE, LOAD and DONE. Reset state is IDLE.
- IDLE:
  - start moves to LOAD and zeroes count, sum and overflow on the same edge.
  - in_valid is ignored. No overflow is recorded.
- LOAD:
  - Each cycle with in_valid=1 writes in_data to mem[count], increments count, and adds in_data to sum.
  - Go to DONE on the edge where in_last=1, or where count becomes N.
  - If in_valid and in_last occur in the same cycle, the sample is captured, then the FSM goes to DONE.
  - in_last with in_valid=0 goes to DONE with no write.
- DONE:
  - in_valid=1 sets overflow, drops the sample, and leaves count and sum unchanged.
  - clear moves to IDLE. count, sum and memory contents are held until the next start.
  - A start in DONE is ignored.
- Readback:
  - rd_en in DONE with rd_addr < count returns mem[rd_addr].
  - rd_en in DONE with rd_addr ≥ count returns 0.
  - rd_en outside DONE produces rd_valid=0 and leaves rd_data unchanged.
- Arithmetic:
  - sum is zero-extended accumulation at SW bits. The maximum is N·(2^DATA_W − 1), which fits in SW bits, so there is no wrap.
  - count never exceeds N.
- Memory is not reset. Only the control and status registers are reset.

## Timing
- Reset values:
  - busy=0, done=0, overflow=0, count=0, sum=0, rd_data=0, rd_valid=0; FSM in IDLE.
- Reset during LOAD or DONE aborts immediately and asynchronously. Outputs take their reset values with no clock edge needed.
- busy rises on the edge after start and falls on the edge that enters DONE. done rises on that same edge.
- count and sum reflect a sample on the edge that captures it. Capture latency is 1 cycle.
- Readback latency is 1 cycle: request at edge k gives rd_data and rd_valid=1 after edge k+1. rd_valid is a 1-cycle pulse per request.
- Back-to-back rd_en sustains one read per cycle.
- start and clear are single-cycle pulses. Holding one high has the same effect as a single pulse, because each is honoured only in its own state.
- Inputs are sampled only on rising edges. No combinational path runs from any input to any output.

## Test plan
- **Basic capture.** Reset, start, then 5 valid samples 10, 20, 30, 40, 50, with in_last on the 5th.
  - Expect done=1 one cycle after the 5th, count=5, sum=150, overflow=0.
  - Reading addresses 0–4 returns 10…50 with 1-cycle latency. Reading address 7 returns 0.
- **Full buffer (N=100).** Start, then 102 consecutive valid samples 1…102 with no in_last.
  - Expect done after the 100th sample, count=100, sum=5050.
  - overflow=1 after the 101st sample. mem[99]=100.
- **in_last only.** Start, then in_last=1 with in_valid=0.
  - Expect done=1 with count=0 and sum=0. Any read returns 0.
- **Reset mid-load.** Start, 3 samples, then assert reset_n=0 asynchronously.
  - Expect busy=0 and count=0 immediately.
  - After release, a new start plus 2 samples 7 and 9 gives count=2 and sum=16.
- **Ignored controls.** start in DONE is ignored and state stays DONE. clear in IDLE or LOAD is ignored. rd_en in LOAD gives rd_valid=0. in_valid in IDLE does not change count.
- **Width extreme (N=4).** Feed 4 samples of 2^64−1.
  - Expect sum = 4·(2^64−1) with no wrap, count=4, done=1.
